// File: rtl/debounce_scheduler_if.sv
// Pin-side and user-side signals of the shared-counter debouncer.
// The master modport is the debouncer itself.
interface debounce_scheduler_if #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = $clog2(N_INPUTS)
);
  logic [N_INPUTS-1:0] signal_i;
  logic [N_INPUTS-1:0] stable_o;
  logic [N_INPUTS-1:0] rise_o;
  logic [N_INPUTS-1:0] fall_o;
  logic                busy_o;
  logic [IDX_W-1:0]    grant_o;

  modport master (
    input  signal_i,
    output stable_o, rise_o, fall_o,
    output busy_o, grant_o
  );

  modport slave (
    output signal_i,
    input  stable_o, rise_o, fall_o,
    input  busy_o, grant_o
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Debouncer for N inputs sharing one delay counter,
// handed out round-robin to inputs whose level disagrees with stable.
module debounce_scheduler #(
  parameter int          N_INPUTS      = 4,
  parameter logic [31:0] TIME_DEBOUNCE = 32'd50_000_000
) (
  input logic clk_i,
  input logic rst_i,
  debounce_scheduler_if.master bus
);
  localparam int IDX_W = $clog2(N_INPUTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [N_INPUTS-1:0] meta_q, sync_q;
  logic [N_INPUTS-1:0] stable_q, stable_d;
  logic [N_INPUTS-1:0] rise_q, rise_d;
  logic [N_INPUTS-1:0] fall_q, fall_d;
  logic [N_INPUTS-1:0] pend;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [IDX_W-1:0]    sel;
  logic                target_q, target_d;

  assign pend = sync_q ^ stable_q;

  // Scan downward so the nearest index after last_q wins.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    sel = '0;
    for (int k = N_INPUTS; k >= 1; k--) begin
      j  = (int'(last_q) + k) % N_INPUTS;
      jj = IDX_W'(j);
      if (pend[jj]) sel = jj;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    target_d = target_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          grant_d  = sel;
          target_d = sync_q[sel];
          cnt_d    = '0;
          state_d  = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (sync_q[grant_q] != target_q) begin
          last_d  = grant_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == TIME_DEBOUNCE) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_COMMIT: begin
        stable_d[grant_q] = target_q;
        rise_d[grant_q]   = target_q;
        fall_d[grant_q]   = ~target_q;
        last_d            = grant_q;
        cnt_d             = '0;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      grant_q  <= '0;
      last_q   <= IDX_W'(N_INPUTS - 1);
      target_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      meta_q   <= bus.signal_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      target_q <= target_d;
    end
  end

  assign bus.stable_o = stable_q;
  assign bus.rise_o   = rise_q;
  assign bus.fall_o   = fall_q;
  assign bus.busy_o   = (state_q != ST_IDLE);
  assign bus.grant_o  = grant_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler, N_INPUTS=4, TIME_DEBOUNCE=10.
// Edge 1 is the first clock edge that samples a new input level.
module tb_debounce_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   rise_cnt [N];
  int   fall_cnt [N];
  int   hit;

  always #5 clk = ~clk;

  debounce_scheduler_if #(.N_INPUTS(N)) bus ();

  debounce_scheduler #(
    .N_INPUTS     (N),
    .TIME_DEBOUNCE(32'd10)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        rise_cnt[i] += int'(bus.rise_o[i]);
        fall_cnt[i] += int'(bus.fall_o[i]);
      end
    end
  endtask

  task automatic do_reset();
    bus.signal_i = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    clr_cnt();
  endtask

  initial begin
    bus.signal_i = '0;
    step(2);
    check("rst_stable", 32'(bus.stable_o), 0);
    check("rst_rise", 32'(bus.rise_o), 0);
    check("rst_fall", 32'(bus.fall_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_grant", 32'(bus.grant_o), 0);
    rst = 1'b0;
    step(3);
    clr_cnt();

    // clean rise on input 2
    bus.signal_i[2] = 1'b1;
    step(2);
    check("t1_busy_e2", 32'(bus.busy_o), 0);
    step(1);
    check("t1_busy_e3", 32'(bus.busy_o), 1);
    check("t1_grant", 32'(bus.grant_o), 2);
    step(11);
    check("t1_busy_e14", 32'(bus.busy_o), 1);
    check("t1_stable_e14", 32'(bus.stable_o), 0);
    step(1);
    check("t1_stable_e15", 32'(bus.stable_o), 4'b0100);
    check("t1_rise_e15", 32'(bus.rise_o), 4'b0100);
    check("t1_busy_e15", 32'(bus.busy_o), 0);
    step(1);
    check("t1_rise_e16", 32'(bus.rise_o), 0);
    check("t1_fall_cnt", 32'(fall_cnt[2]), 0);

    // bounce then hold on input 1
    do_reset();
    bus.signal_i[1] = 1'b1;
    step(6);
    bus.signal_i[1] = 1'b0;
    step(12);
    check("t2_abort_busy", 32'(bus.busy_o), 0);
    check("t2_abort_stable", 32'(bus.stable_o), 0);
    check("t2_abort_rise", 32'(rise_cnt[1]), 0);
    bus.signal_i[1] = 1'b1;
    step(14);
    check("t2_stable_e14", 32'(bus.stable_o), 0);
    step(1);
    check("t2_stable_e15", 32'(bus.stable_o), 4'b0010);
    check("t2_rise_e15", 32'(bus.rise_o), 4'b0010);
    step(2);
    check("t2_rise_cnt", 32'(rise_cnt[1]), 1);
    check("t2_fall_cnt", 32'(fall_cnt[1]), 0);

    // inputs 0 and 3 together
    do_reset();
    bus.signal_i = 4'b1001;
    step(15);
    check("t3_stable_e15", 32'(bus.stable_o), 4'b0001);
    check("t3_rise_e15", 32'(bus.rise_o), 4'b0001);
    step(1);
    check("t3_grant_e16", 32'(bus.grant_o), 3);
    step(11);
    check("t3_stable_e27", 32'(bus.stable_o), 4'b0001);
    step(1);
    check("t3_stable_e28", 32'(bus.stable_o), 4'b1001);
    check("t3_rise_e28", 32'(bus.rise_o), 4'b1000);
    step(3);
    check("t3_rise_cnt0", 32'(rise_cnt[0]), 1);
    check("t3_rise_cnt3", 32'(rise_cnt[3]), 1);

    // input 1 chatters, input 2 must still get through
    do_reset();
    hit = 0;
    bus.signal_i[2] = 1'b1;
    for (int i = 0; i < 54 && hit == 0; i++) begin
      if (i % 4 == 0) bus.signal_i[1] = ~bus.signal_i[1];
      step(1);
      if (bus.stable_o[2]) hit = i + 1;
    end
    check("t4_in_bound", 32'(hit != 0 && hit <= 54), 1);
    check("t4_edge", 32'(hit), 20);
    check("t4_stable1", 32'(bus.stable_o[1]), 0);
    check("t4_rise_cnt1", 32'(rise_cnt[1]), 0);
    bus.signal_i[1] = 1'b0;

    // falling edge on input 0
    do_reset();
    bus.signal_i[0] = 1'b1;
    step(16);
    check("t5_stable_hi", 32'(bus.stable_o), 4'b0001);
    clr_cnt();
    bus.signal_i[0] = 1'b0;
    step(14);
    check("t5_stable_e14", 32'(bus.stable_o), 4'b0001);
    step(1);
    check("t5_stable_e15", 32'(bus.stable_o), 0);
    check("t5_fall_e15", 32'(bus.fall_o), 4'b0001);
    check("t5_rise_e15", 32'(bus.rise_o), 0);
    step(3);
    check("t5_fall_cnt", 32'(fall_cnt[0]), 1);
    check("t5_rise_cnt", 32'(rise_cnt[0]), 0);

    // reset in the middle of a delay
    do_reset();
    bus.signal_i[3] = 1'b1;
    step(16);
    check("t6_pre_stable", 32'(bus.stable_o), 4'b1000);
    bus.signal_i[0] = 1'b1;
    step(10);
    check("t6_pre_busy", 32'(bus.busy_o), 1);
    rst = 1'b1;
    #1;
    check("t6_stable", 32'(bus.stable_o), 0);
    check("t6_rise", 32'(bus.rise_o), 0);
    check("t6_fall", 32'(bus.fall_o), 0);
    check("t6_busy", 32'(bus.busy_o), 0);
    check("t6_grant", 32'(bus.grant_o), 0);
    step(2);
    rst = 1'b0;
    clr_cnt();
    step(14);
    check("t6_stable_e14", 32'(bus.stable_o), 0);
    step(1);
    check("t6_stable_e15", 32'(bus.stable_o[0]), 1);
    check("t6_rise_e15", 32'(bus.rise_o), 4'b0001);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N_INPUTS push-button/switch lines using one shared 32-bit delay counter instead of one counter per input.
- A round-robin scheduler grants the counter to one input at a time whose synchronized level differs from its debounced level.
- Sits between the board pins and the user logic, replacing per-input debounce instances where counter area matters.
- Outputs per-input stable levels plus one-cycle rise/fall event pulses.

Parameters:
- N_INPUTS, 4, number of raw inputs; legal range 2..16.
- TIME_DEBOUNCE, 50_000_000, counter terminal value in clocks (1 s at 50 MHz); legal range 1..2^32-1.
- IDX_W, $clog2(N_INPUTS), width of the grant index; derived, not overridden.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- signal_i  in  N_INPUTS  raw asynchronous inputs.
- stable_o  out  N_INPUTS  debounced levels.
- rise_o  out  N_INPUTS  one-cycle pulse when stable_o[i] goes 0->1.
- fall_o  out  N_INPUTS  one-cycle pulse when stable_o[i] goes 1->0.
- busy_o  out  1  high whenever the FSM is not in ST_IDLE.
- grant_o  out  IDX_W  index currently owning the counter; valid only while busy_o=1.

Behaviour:
- Reset (async, rst_i=1):
  - State ST_IDLE; counter=0.
  - Synchronizers, stable_o, rise_o and fall_o all 0.
  - busy_o=0; grant_o=0; last_grant=N_INPUTS-1, so input 0 has first priority.
- Synchronizer: 2-flop per input; sync[i] is the second flop.
- Pending: pend[i] = sync[i] != stable_o[i].
- ST_IDLE:
  - If any pend, select the first pending index searching from last_grant+1 upward, wrapping modulo N_INPUTS.
  - Latch grant=sel and target=sync[sel]; clear counter; go to ST_DELAY.
  - If no input is pending, stay in ST_IDLE.
- ST_DELAY:
  - If sync[grant] != target (bounce): abort, last_grant<=grant, counter<=0, go to ST_IDLE. stable_o is unchanged.
  - Else if counter == TIME_DEBOUNCE: go to ST_COMMIT, counter holds.
  - Else counter<=counter+1.
- ST_COMMIT:
  - stable_o[grant]<=target.
  - rise_o[grant]<=target; fall_o[grant]<=~target.
  - last_grant<=grant; counter<=0; go to ST_IDLE.
- rise_o and fall_o are registered and high for exactly one clock, coincident with the first cycle of the new stable_o value. All other bits are 0.
- Latency, isolated clean edge with the scheduler idle: stable_o[i] changes at rising edge TIME_DEBOUNCE+5, counting the first edge that samples the new level as edge 1.
  - Synchronizer: 2 edges.
  - ST_IDLE: 1 edge.
  - ST_DELAY: TIME_DEBOUNCE+1 edges.
  - ST_COMMIT: 1 edge.
- Counter arithmetic:
  - Unsigned 32-bit compare uses ==; it never wraps because it stops at TIME_DEBOUNCE.
  - Counter increments only in ST_DELAY.
- Simultaneous pending inputs: one is served at a time in round-robin order. The others wait, and their pend is re-evaluated on return to ST_IDLE. An input that returned to its stable level while waiting is never served and produces no pulse.
- Inputs other than grant that change during ST_DELAY have no effect on the current delay.
- An abort rotates priority, so a continuously bouncing input cannot starve the others.
- Worst-case service wait for any input is (N_INPUTS-1)*(TIME_DEBOUNCE+3) clocks.
- An input pending already high at reset release is debounced normally to 1 and produces a rise pulse.
- Reset asserted mid-ST_DELAY or mid-ST_COMMIT takes effect immediately:
  - All outputs return to reset values.
  - No pulse is emitted.

Test Plan (TIME_DEBOUNCE=10, N_INPUTS=4):
1. signal_i[2] 0->1 clean, held -> stable_o[2]=1 and rise_o[2]=1 for one cycle at edge 15; busy_o high edges 3-14; grant_o=2.
2. signal_i[1] 0->1, back to 0 after 6 clocks, then 1 held -> first attempt aborts with no pulse; stable_o[1]=1 at 15 clocks after the final edge; fall_o stays 0 throughout.
3. signal_i[0] and signal_i[3] rise on the same edge -> input 0 committed first (edge 15), input 3 committed 13 clocks later (edge 28); each gets exactly one rise_o pulse.
4. signal_i[1] toggles every 4 clocks forever while signal_i[2] rises and holds -> input 2 still reaches stable_o[2]=1 within (N_INPUTS-1)*(TIME_DEBOUNCE+3)+15 clocks.
5. Input 0 stable at 1, then 1->0 -> fall_o[0] pulses once; rise_o[0] stays 0.
6. rst_i asserted while counter=7 in ST_DELAY -> stable_o, rise_o, fall_o, busy_o and grant_o are all 0 before the next clock edge. After release with signal_i[0]=1 held, stable_o[0]=1 at edge 15.
